// File: rtl/fpu_mul_unit.sv
// IEEE-754 binary32 multiplier for the FPU arithmetic sequencer.
// The 24x24 mantissa product is built by a sequential shift-add loop that
// handles one multiplier bit per add/shift state pair. The product is then
// normalised, rounded to nearest even and packed. Zero, denormal, infinity
// and NaN operands skip the loop and produce their result directly.
module fpu_mul_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    mul_idle_st          = 3'd0,
    mul_start_st         = 3'd1,
    mul_product_add_st   = 3'd2,
    mul_product_shift_st = 3'd3,
    mul_result_set_st    = 3'd4,
    mul_result_valid_st  = 3'd5
  } e_mul_states;

  e_mul_states state_q, state_d;

  logic [31:0] a_q, b_q;
  logic [47:0] prod_q;
  logic        carry_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;

  // Operand fields decoded from the latched operands; they stay stable for the whole op.
  logic        sign;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        special;
  logic [31:0] special_res;

  assign sign   = a_q[31] ^ b_q[31];
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign ma     = {1'b1, a_q[22:0]};
  assign mb     = {1'b1, b_q[22:0]};
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Special results in precedence order: NaN, infinity, flushed zero.
  always_comb begin
    special_res = {sign, 31'd0};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_res = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      special_res = {sign, 31'h7F80_0000};
  end

  // Normalise the raw 48-bit product, round to nearest even and pack.
  function automatic logic [31:0] round_pack(input logic        s,
                                             input logic [7:0]  exp_a,
                                             input logic [7:0]  exp_b,
                                             input logic [47:0] p);
    logic [22:0]        frac;
    logic [23:0]        frac_inc;
    logic               guard, sticky, n, rc, rup;
    logic signed [9:0]  e;
    if (p[47]) begin
      frac   = p[46:24];
      guard  = p[23];
      sticky = |p[22:0];
      n      = 1'b1;
    end else begin
      frac   = p[45:23];
      guard  = p[22];
      sticky = |p[21:0];
      n      = 1'b0;
    end
    rup      = guard & (sticky | frac[0]);
    frac_inc = {1'b0, frac} + {23'd0, rup};
    rc       = frac_inc[23];
    frac     = frac_inc[22:0];
    e = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127
        + $signed({9'd0, n}) + $signed({9'd0, rc});
    if (e >= 10'sd255)
      round_pack = {s, 31'h7F80_0000};
    else if (e <= 10'sd0)
      round_pack = {s, 31'd0};
    else
      round_pack = {s, e[7:0], frac};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= mul_idle_st;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d = mul_idle_st;
    done    = 1'b0;
    busy    = 1'b1;
    case (state_q)
      mul_idle_st: begin
        busy    = 1'b0;
        state_d = start ? mul_start_st : mul_idle_st;
      end
      mul_start_st:
        state_d = special ? mul_result_set_st : mul_product_add_st;
      mul_product_add_st:
        state_d = mul_product_shift_st;
      mul_product_shift_st:
        state_d = (cnt_q == 5'd23) ? mul_result_set_st : mul_product_add_st;
      mul_result_set_st:
        state_d = mul_result_valid_st;
      mul_result_valid_st: begin
        done    = 1'b1;
        state_d = start ? mul_result_valid_st : mul_idle_st;
      end
      default: begin
        busy    = 1'b0;
        state_d = mul_idle_st;
      end
    endcase
  end

  // Operand latch, shift-add product loop and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      prod_q   <= 48'd0;
      carry_q  <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        mul_idle_st: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        mul_start_st: begin
          prod_q  <= 48'd0;
          carry_q <= 1'b0;
          cnt_q   <= 5'd0;
        end
        mul_product_add_st: begin
          if (mb[cnt_q])
            {carry_q, prod_q[47:24]} <= {1'b0, prod_q[47:24]} + {1'b0, ma};
        end
        mul_product_shift_st: begin
          prod_q  <= {carry_q, prod_q[47:1]};
          carry_q <= 1'b0;
          cnt_q   <= cnt_q + 5'd1;
        end
        mul_result_set_st: begin
          result_q <= special ? special_res : round_pack(sign, ea, eb, prod_q);
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
